// File: rtl/rs_ms_1.sv
// rs_ms_1: master-slave RS flip-flop with 3-input AND-gated set/reset
// and asynchronous preset/clear (7472-style pulse-triggered cell).
//
// The master latches next(S, R, slave) on the clk rising edge. The slave,
// and therefore Q, copies the master on the following clk falling edge.
//
// Asynchronous priority, highest first: rst_n low, CLR high, PRE high.
// While any of them is active, both stages are forced and clock edges are
// ignored.
//
// Optional feature macro: RS_MS_TOGGLE_EN
//   undefined: S=R=1 holds the stored value.
//   defined:   S=R=1 toggles the stored value (JK semantics).
module rs_ms_1 #(
  parameter logic RST_Q = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic PRE,
  input  logic CLR,
  input  logic R1,
  input  logic R2,
  input  logic R3,
  input  logic S1,
  input  logic S2,
  input  logic S3,
  output logic Q,
  output logic QBAR
);

  logic s_en;
  logic r_en;
  logic master_q;
  logic master_d;
  logic slave_q;

  // A partially asserted input group counts as deasserted.
  assign s_en = S1 & S2 & S3;
  assign r_en = R1 & R2 & R3;

  // Next master value from the gated set/reset and the current slave value.
  always_comb begin
    master_d = slave_q;
    unique case ({s_en, r_en})
      2'b10:   master_d = 1'b1;
      2'b01:   master_d = 1'b0;
`ifdef RS_MS_TOGGLE_EN
      2'b11:   master_d = ~slave_q;
`else
      2'b11:   master_d = slave_q;
`endif
      default: master_d = slave_q;
    endcase
  end

  // Master stage: samples on the rising edge; async controls force it.
  always_ff @(posedge clk or negedge rst_n or posedge CLR or posedge PRE) begin
    if (!rst_n) begin
      master_q <= RST_Q;
    end else if (CLR) begin
      master_q <= 1'b0;
    end else if (PRE) begin
      master_q <= 1'b1;
    end else begin
      master_q <= master_d;
    end
  end

  // Slave stage: copies the master on the falling edge; async controls force it.
  always_ff @(negedge clk or negedge rst_n or posedge CLR or posedge PRE) begin
    if (!rst_n) begin
      slave_q <= RST_Q;
    end else if (CLR) begin
      slave_q <= 1'b0;
    end else if (PRE) begin
      slave_q <= 1'b1;
    end else begin
      slave_q <= master_q;
    end
  end

  // Complementary outputs come straight from the slave, so Q never equals QBAR.
  assign Q    = slave_q;
  assign QBAR = ~slave_q;

endmodule

// File: tb/tb_rs_ms_1.sv
// tb_rs_ms_1: self-checking bench for the rs_ms_1 master-slave RS flip-flop.
// Table-driven vectors, hand-written async/edge sequences, and a randomized
// run checked against a behavioural model with an expected-value queue.
module tb_rs_ms_1;

  localparam logic RST_Q = 1'b0;

`ifdef RS_MS_TOGGLE_EN
  localparam logic TOG = 1'b1;
`else
  localparam logic TOG = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic pre;
  logic clr;
  logic r1, r2, r3;
  logic s1, s2, s3;
  logic q;
  logic qbar;

  int checks;
  int errors;

  logic       q_model;
  logic [0:0] exp_q[$];

  typedef struct {
    logic [2:0] s;
    logic [2:0] r;
    logic       q0;
    logic       q1;
  } vec_t;

  vec_t vecs[12];

  rs_ms_1 #(.RST_Q(RST_Q)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .PRE  (pre),
    .CLR  (clr),
    .R1   (r1),
    .R2   (r2),
    .R3   (r3),
    .S1   (s1),
    .S2   (s2),
    .S3   (s3),
    .Q    (q),
    .QBAR (qbar)
  );

  // ---------------- clock / reset ----------------
  // Edges are placed explicitly so the bench can produce lone edges.
  task automatic clk_rise();
    #5 clk = 1'b1;
    #2;
  endtask

  task automatic clk_fall();
    #5 clk = 1'b0;
    #2;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_sr(input logic [2:0] s, input logic [2:0] r);
    s1 = s[0]; s2 = s[1]; s3 = s[2];
    r1 = r[0]; r2 = r[1]; r3 = r[2];
    #1;
  endtask

  task automatic force_q(input logic v);
    if (v) pre = 1'b1; else clr = 1'b1;
    #1;
    pre = 1'b0;
    clr = 1'b0;
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic exp);
    checks++;
    if (q !== exp || qbar !== ~exp) begin
      errors++;
      $display("FAIL %s: Q=%b QBAR=%b, required Q=%b QBAR=%b", name, q, qbar, exp, ~exp);
    end
  endtask

  // Stored value after a sampling edge, from the truth table.
  function automatic logic next_val(input logic s, input logic r, input logic cur);
    if (s && !r) return 1'b1;
    if (r && !s) return 1'b0;
    if (s && r)  return TOG ? ~cur : cur;
    return cur;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    pre = 1'b0;
    clr = 1'b0;
    set_sr(3'b000, 3'b000);

    // ---- reset, then clear without clock activity ----
    #3;
    chk("reset", RST_Q);
    clr = 1'b1;
    #2;
    chk("clr_under_reset", 1'b0);
    rst_n = 1'b1;
    clr = 1'b0;
    #2;
    clk_rise();
    chk("post_release_rise", 1'b0);
    clk_fall();
    chk("post_release_fall", 1'b0);

    // ---- table-driven vectors ----
    vecs[0]  = '{s: 3'b111, r: 3'b000, q0: 1'b0, q1: 1'b1};
    vecs[1]  = '{s: 3'b111, r: 3'b000, q0: 1'b1, q1: 1'b1};
    vecs[2]  = '{s: 3'b000, r: 3'b111, q0: 1'b1, q1: 1'b0};
    vecs[3]  = '{s: 3'b000, r: 3'b111, q0: 1'b0, q1: 1'b0};
    vecs[4]  = '{s: 3'b011, r: 3'b000, q0: 1'b0, q1: 1'b0};
    vecs[5]  = '{s: 3'b000, r: 3'b011, q0: 1'b1, q1: 1'b1};
    vecs[6]  = '{s: 3'b000, r: 3'b000, q0: 1'b1, q1: 1'b1};
    vecs[7]  = '{s: 3'b000, r: 3'b000, q0: 1'b0, q1: 1'b0};
    vecs[8]  = '{s: 3'b111, r: 3'b111, q0: 1'b1, q1: TOG ? 1'b0 : 1'b1};
    vecs[9]  = '{s: 3'b111, r: 3'b111, q0: 1'b0, q1: TOG ? 1'b1 : 1'b0};
    vecs[10] = '{s: 3'b101, r: 3'b110, q0: 1'b1, q1: 1'b1};
    vecs[11] = '{s: 3'b111, r: 3'b101, q0: 1'b0, q1: 1'b1};
    for (int i = 0; i < 12; i++) begin
      force_q(vecs[i].q0);
      set_sr(vecs[i].s, vecs[i].r);
      clk_rise();
      chk($sformatf("vec%0d_rise", i), vecs[i].q0);
      clk_fall();
      chk($sformatf("vec%0d_fall", i), vecs[i].q1);
    end

    // ---- S=R=1 for two cycles from Q=1 ----
    force_q(1'b1);
    set_sr(3'b111, 3'b111);
    clk_rise(); clk_fall();
    chk("both_cycle1", TOG ? 1'b0 : 1'b1);
    clk_rise(); clk_fall();
    chk("both_cycle2", 1'b1);

    // ---- async controls mid clk-high ----
    force_q(1'b0);
    set_sr(3'b000, 3'b000);
    clk_rise();
    pre = 1'b1;
    #1;
    chk("pre_mid_high", 1'b1);
    clr = 1'b1;
    #1;
    chk("clr_over_pre", 1'b0);
    pre = 1'b0;
    clr = 1'b0;
    #1;
    pre = 1'b1;
    #1;
    pre = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cycle", RST_Q);
    rst_n = 1'b1;
    #1;
    clk_fall();
    chk("rst_release_high_fall", RST_Q);

    // ---- preset released while clk high: forced value survives the fall ----
    clk_rise();
    pre = 1'b1;
    #1;
    pre = 1'b0;
    set_sr(3'b000, 3'b111);
    clk_fall();
    chk("pre_release_high_fall", 1'b1);

    // ---- input activity without a posedge, then a lone posedge ----
    force_q(1'b0);
    for (int i = 0; i < 6; i++) begin
      set_sr(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      #2;
    end
    chk("no_posedge_activity", 1'b0);
    set_sr(3'b111, 3'b000);
    clk_rise();
    chk("lone_posedge", 1'b0);
    set_sr(3'b000, 3'b111);
    #3;
    chk("lone_posedge_input_change", 1'b0);
    clk_fall();
    chk("lone_posedge_then_fall", 1'b1);

    // ---- randomized run against the behavioural model ----
    force_q(1'b0);
    q_model = 1'b0;
    exp_q.delete();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: begin rst_n = 1'b0; q_model = RST_Q; end
          1: begin clr = 1'b1;   q_model = 1'b0;  end
          2: begin pre = 1'b1;   q_model = 1'b1;  end
          default: begin pre = 1'b1; clr = 1'b1; q_model = 1'b0; end
        endcase
        #1;
        chk("rnd_async", q_model);
        rst_n = 1'b1;
        pre = 1'b0;
        clr = 1'b0;
        exp_q.delete();
        #1;
      end
      s1 = ($urandom_range(0, 3) != 0);
      s2 = ($urandom_range(0, 3) != 0);
      s3 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 3) != 0);
      r2 = ($urandom_range(0, 3) != 0);
      r3 = ($urandom_range(0, 3) != 0);
      #1;
      exp_q.push_back(next_val(s1 & s2 & s3, r1 & r2 & r3, q_model));
      clk_rise();
      chk("rnd_rise", q_model);
      set_sr(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      clk_fall();
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rnd_queue: expected queue empty at fall, required one entry");
      end else begin
        q_model = exp_q.pop_front();
        chk("rnd_fall", q_model);
      end
    end

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
